// File: rtl/key_event_if.sv
// Key level inputs and the single event channel of the clock-setting UI.
// master is the key event controller; slave is the key source / event consumer.
interface key_event_if #(
  parameter int N_KEYS = 4,
  parameter int CODE_W = 2
);
  logic [N_KEYS-1:0] key_in;
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_long;
  logic              key_rpt;
  logic              busy;

  modport master (
    input  key_in,
    output key_valid, key_code, key_long, key_rpt, busy
  );

  modport slave (
    output key_in,
    input  key_valid, key_code, key_long, key_rpt, busy
  );
endinterface

// File: rtl/key_event_module.sv
// Grants one debounced active-low key at a time and turns it into short, long
// and auto-repeat events on a single registered event channel.
module key_event_module #(
  parameter int N_KEYS     = 4,
  parameter int CODE_W     = 2,
  parameter int CNT_W      = 26,
  parameter int LONG_CNT   = 50000000,
  parameter int REPEAT_CNT = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  key_event_if.master kif
);

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    PRESS    = 2'd2,
    REPEAT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              valid_reg;
  logic [CODE_W-1:0] code_reg;
  logic              long_reg;
  logic              rpt_reg;
  logic              busy_reg;

  logic [CODE_W-1:0] grant_idx;
  logic              all_released;
  logic              granted_released;

  // Scan from the top down so the lowest pressed index is the one left standing.
  always_comb begin
    grant_idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (!kif.key_in[i]) begin
        grant_idx = CODE_W'(i);
      end
    end
  end

  assign all_released     = &kif.key_in;
  assign granted_released = kif.key_in[code_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= WAIT_REL;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      code_reg  <= '0;
      long_reg  <= 1'b0;
      rpt_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      long_reg  <= 1'b0;
      rpt_reg   <= 1'b0;
      busy_reg  <= 1'b1;
      case (state_reg)
        WAIT_REL: begin
          if (all_released) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        IDLE: begin
          if (!all_released) begin
            code_reg  <= grant_idx;
            cnt_reg   <= '0;
            state_reg <= PRESS;
          end else begin
            busy_reg  <= 1'b0;
          end
        end
        PRESS: begin
          // Release wins over the terminal count, so a late release is still short.
          if (granted_released) begin
            valid_reg <= 1'b1;
            state_reg <= WAIT_REL;
          end else if (cnt_reg == LONG_LAST) begin
            valid_reg <= 1'b1;
            long_reg  <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= REPEAT;
          end else begin
            cnt_reg   <= cnt_reg + 1'b1;
          end
        end
        REPEAT: begin
          if (granted_released) begin
            state_reg <= WAIT_REL;
          end else if (cnt_reg == REPEAT_LAST) begin
            valid_reg <= 1'b1;
            long_reg  <= 1'b1;
            rpt_reg   <= 1'b1;
            cnt_reg   <= '0;
          end else begin
            cnt_reg   <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= WAIT_REL;
        end
      endcase
    end
  end

  assign kif.key_valid = valid_reg;
  assign kif.key_code  = code_reg;
  assign kif.key_long  = long_reg;
  assign kif.key_rpt   = rpt_reg;
  assign kif.busy      = busy_reg;

endmodule

// File: tb/tb_key_event_module.sv
// Bench for key_event_module: hand-derived per-cycle vector table, reset corner
// sequences, and randomized key activity against an event-level reference model.
module tb_key_event_module;

  localparam int N  = 4;
  localparam int CW = 2;
  localparam int L  = 8;
  localparam int R  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  key_event_if #(.N_KEYS(N), .CODE_W(CW)) kif ();

  key_event_module #(
    .N_KEYS(N), .CODE_W(CW), .CNT_W(8), .LONG_CNT(L), .REPEAT_CNT(R)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kif  (kif)
  );

  // Expected outputs packed as {valid, code[1:0], long, rpt, busy}.
  typedef struct {
    logic [3:0] keys;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [5:0] pk(input logic v, input logic [1:0] c,
                                    input logic l, input logic r, input logic b);
    return {v, c, l, r, b};
  endfunction

  function automatic void add(input logic [3:0] k, input logic [5:0] e);
    vec_t t;
    t.keys = k;
    t.exp  = e;
    vecs.push_back(t);
  endfunction

  function automatic logic [5:0] obs();
    return {kif.key_valid, kif.key_code, kif.key_long, kif.key_rpt, kif.busy};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got {v,code,long,rpt,busy}=%b required %b at %0t",
               name, act, exp, $time);
    end
  endtask

  // Apply one key pattern for one clock; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic [3:0] k);
    kif.key_in = k;
    @(posedge clk);
    #1;
  endtask

  // Reference model: tracks which key is granted and how many edges it has been held.
  int         m_gr;
  bit         m_lock;
  int         m_hold;
  logic [1:0] m_code;
  logic [5:0] m_exp;

  function automatic void model_reset();
    m_gr   = -1;
    m_lock = 1'b1;
    m_hold = 0;
    m_code = '0;
    m_exp  = '0;
  endfunction

  function automatic void model_step(input logic [3:0] k);
    logic v, l, r;
    v = 1'b0; l = 1'b0; r = 1'b0;
    if (m_gr < 0) begin
      if (m_lock) begin
        if (k == 4'hF) m_lock = 1'b0;
      end else if (k != 4'hF) begin
        for (int i = 0; i < N; i++) begin
          if (!k[i] && m_gr < 0) m_gr = i;
        end
        m_hold = 0;
        m_code = 2'(m_gr);
      end
    end else begin
      m_hold++;
      if (k[m_gr]) begin
        v      = (m_hold <= L);
        m_gr   = -1;
        m_lock = 1'b1;
      end else if (m_hold == L) begin
        v = 1'b1; l = 1'b1;
      end else if (m_hold > L && (m_hold - L) % R == 0) begin
        v = 1'b1; l = 1'b1; r = 1'b1;
      end
    end
    m_exp = pk(v, m_code, l, r, !(m_gr < 0 && !m_lock));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed table: reset released with all keys up.
    add(4'hF, pk(0, 0, 0, 0, 0));
    add(4'hF, pk(0, 0, 0, 0, 0));
    // Short press of key 1 for three cycles.
    repeat (3) add(4'hD, pk(0, 1, 0, 0, 1));
    add(4'hF, pk(1, 1, 0, 0, 1));
    add(4'hF, pk(0, 1, 0, 0, 0));
    add(4'hF, pk(0, 1, 0, 0, 0));
    // Key 2 held for 20 cycles: long at +8, repeats at +12 and +16.
    for (int k = 0; k < 20; k++) begin
      logic ev, rp;
      ev = (k == 8) || (k == 12) || (k == 16);
      rp = (k == 12) || (k == 16);
      add(4'hB, pk(ev, 2, ev, rp, 1));
    end
    add(4'hF, pk(0, 2, 0, 0, 1));
    add(4'hF, pk(0, 2, 0, 0, 0));
    // Keys 3 and 0 together: key 0 wins; key 3 stays blocked after key 0 releases.
    add(4'h6, pk(0, 0, 0, 0, 1));
    add(4'h6, pk(0, 0, 0, 0, 1));
    add(4'h7, pk(1, 0, 0, 0, 1));
    add(4'h7, pk(0, 0, 0, 0, 1));
    add(4'h7, pk(0, 0, 0, 0, 1));
    add(4'hF, pk(0, 0, 0, 0, 0));
    add(4'hF, pk(0, 0, 0, 0, 0));
    // Release on the terminal cycle of the long count: short event only.
    add(4'hD, pk(0, 1, 0, 0, 1));
    repeat (7) add(4'hD, pk(0, 1, 0, 0, 1));
    add(4'hF, pk(1, 1, 0, 0, 1));
    add(4'hF, pk(0, 1, 0, 0, 0));

    kif.key_in = 4'hF;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs(), pk(0, 0, 0, 0, 0));
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].keys);
      check($sformatf("vec[%0d]", i), obs(), vecs[i].exp);
    end

    // Key 0 held through reset deassertion stays blocked until released.
    kif.key_in = 4'hE;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    check("stuck_key_reset", obs(), pk(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(4'hE);
      check($sformatf("stuck_hold[%0d]", k), obs(), pk(0, 0, 0, 0, 1));
    end
    cycle(4'hF); check("stuck_release", obs(), pk(0, 0, 0, 0, 0));
    cycle(4'hE); check("after_stuck_grant", obs(), pk(0, 0, 0, 0, 1));
    cycle(4'hE); check("after_stuck_hold", obs(), pk(0, 0, 0, 0, 1));
    cycle(4'hF); check("after_stuck_short", obs(), pk(1, 0, 0, 0, 1));
    cycle(4'hF); check("after_stuck_idle", obs(), pk(0, 0, 0, 0, 0));

    // Async reset in the middle of auto-repeat.
    cycle(4'h7); check("rep_grant", obs(), pk(0, 3, 0, 0, 1));
    for (int k = 1; k <= 10; k++) begin
      cycle(4'h7);
      check($sformatf("rep_hold[%0d]", k), obs(), pk(k == 8, 3, k == 8, 0, 1));
    end
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid_repeat", obs(), pk(0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("async_reset_held", obs(), pk(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(4'h7);
      check($sformatf("post_reset_block[%0d]", k), obs(), pk(0, 0, 0, 0, 1));
    end
    cycle(4'hF); check("post_reset_idle", obs(), pk(0, 0, 0, 0, 0));

    // Randomized key activity against the reference model.
    kif.key_in = 4'hF;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check("rand_reset", obs(), m_exp);
    rst_n = 1'b1;
    for (int s = 0; s < 70; s++) begin
      logic [3:0] k;
      int         sel;
      int         len;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       k = 4'hF;
        1:       k = ~(4'b0001 << $urandom_range(0, 3));
        default: k = 4'($urandom_range(0, 15));
      endcase
      len = $urandom_range(1, 22);
      for (int c = 0; c < len; c++) begin
        cycle(k);
        model_step(k);
        check($sformatf("rand[%0d.%0d] keys=%b", s, c, k), obs(), m_exp);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
